// File: rtl/gpsdo_pkg.sv
// Shared GPSDO loop definitions: sequencer state encoding, PID gain selects
// and the phase-error magnitude helper.
package gpsdo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_COARSE   = 3'd2,
    ST_FINE     = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_HOLDOVER = 3'd5
  } state_e;

  localparam logic [1:0] GAIN_COARSE = 2'd0;
  localparam logic [1:0] GAIN_FINE   = 2'd1;
  localparam logic [1:0] GAIN_LOCK   = 2'd2;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned GOOD_W  = 5;

  // 25-bit signed difference cannot overflow for a 24-bit count and nominal.
  function automatic logic [PHASE_W-1:0] phase_abs_err(input logic [PHASE_W-1:0] phase,
                                                      input logic [PHASE_W-1:0] nominal);
    logic signed [PHASE_W:0] err;
    err = $signed({1'b0, phase}) - $signed({1'b0, nominal});
    return err[PHASE_W] ? PHASE_W'(-err) : err[PHASE_W-1:0];
  endfunction

endpackage

// File: rtl/loop_sequencer_if.sv
// Measurement strobe in, PID/divider/status controls out; no backpressure,
// the measurement side owns the strobe and the sequencer always accepts it.
interface loop_sequencer_if;
  logic [23:0] Measure_Phase;
  logic        Measure_Done;
  logic        Loop_En;
  logic [1:0]  Loop_Gain_Sel;
  logic        Integ_Clear;
  logic        DIV_RST;
  logic        Holdover;
  logic        Led_Lock;
  logic [2:0]  State;

  modport master (
    output Measure_Phase, Measure_Done,
    input  Loop_En, Loop_Gain_Sel, Integ_Clear, DIV_RST, Holdover, Led_Lock, State
  );

  modport slave (
    input  Measure_Phase, Measure_Done,
    output Loop_En, Loop_Gain_Sel, Integ_Clear, DIV_RST, Holdover, Led_Lock, State
  );
endinterface

// File: rtl/loop_sequencer_watchdog.sv
// PPS loss detector: counts cycles since the last kick, saturating at PPS_TIMEOUT.
// expired is a level; a kick in the terminal cycle suppresses it.
module pps_watchdog #(
  parameter int unsigned PPS_TIMEOUT = 60_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(PPS_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(PPS_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (kick || !arm) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = arm && !kick && (cnt_q == LIMIT);

endmodule

// File: rtl/loop_sequencer.sv
// GPSDO supervisory FSM: classifies each per-second count and sequences align/coarse/fine/lock/holdover.
// Strobe to new outputs is 2 edges; every strobe is accepted, including back-to-back ones.
module loop_sequencer
  import gpsdo_pkg::*;
#(
  parameter int unsigned NOMINAL     = 1_000_000,
  parameter int unsigned COARSE_TH   = 50,
  parameter int unsigned FINE_TH     = 4,
  parameter int unsigned UNLOCK_TH   = 20,
  parameter int unsigned COARSE_CNT  = 4,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned PPS_TIMEOUT = 60_000_000
) (
  input  logic             CLK_SYS,
  input  logic             CLK_RST,
  loop_sequencer_if.slave  bus
);

  localparam logic [PHASE_W-1:0] NOM_V      = PHASE_W'(NOMINAL);
  localparam logic [PHASE_W-1:0] COARSE_LIM = PHASE_W'(COARSE_TH);
  localparam logic [PHASE_W-1:0] FINE_LIM   = PHASE_W'(FINE_TH);
  localparam logic [PHASE_W-1:0] UNLOCK_LIM = PHASE_W'(UNLOCK_TH);
  localparam logic [GOOD_W-1:0]  COARSE_N   = GOOD_W'(COARSE_CNT);
  localparam logic [GOOD_W-1:0]  LOCK_N     = GOOD_W'(LOCK_CNT);

  logic               done_q, done_d;
  logic [PHASE_W-1:0] abs_err_q, abs_err_d;
  state_e             state_q, state_d;
  logic [GOOD_W-1:0]  good_q, good_d, good_inc;
  logic               div_rst_q, div_rst_d;
  logic               integ_clear_q, integ_clear_d;
  logic               wd_arm, wd_expired;

  // Stage 1: capture the sample; the count is only meaningful with its strobe.
  always_comb begin
    done_d    = bus.Measure_Done;
    abs_err_d = abs_err_q;
    if (bus.Measure_Done) begin
      abs_err_d = phase_abs_err(bus.Measure_Phase, NOM_V);
    end
  end

  assign wd_arm = (state_q == ST_ALIGN) || (state_q == ST_COARSE) ||
                  (state_q == ST_FINE)  || (state_q == ST_LOCKED);

  pps_watchdog #(
    .PPS_TIMEOUT (PPS_TIMEOUT)
  ) u_watchdog (
    .clk     (CLK_SYS),
    .rst_n   (CLK_RST),
    .arm     (wd_arm),
    .kick    (bus.Measure_Done),
    .expired (wd_expired)
  );

  // Stage 2: state, good counter and one-cycle pulses.
  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    div_rst_d     = 1'b0;
    integ_clear_d = 1'b0;
    good_inc      = (good_q == '1) ? good_q : good_q + GOOD_W'(1);

    case (state_q)
      ST_IDLE, ST_HOLDOVER: begin
        if (done_q) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (done_q) state_d = ST_COARSE;
      end
      ST_COARSE: begin
        if (done_q) begin
          good_d = (abs_err_q <= COARSE_LIM) ? good_inc : '0;
          if (good_d == COARSE_N) state_d = ST_FINE;
        end
      end
      ST_FINE: begin
        if (done_q) begin
          if (abs_err_q > COARSE_LIM) begin
            state_d = ST_ALIGN;
          end else begin
            good_d = (abs_err_q <= FINE_LIM) ? good_inc : '0;
            if (good_d == LOCK_N) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (done_q) begin
          if (abs_err_q > COARSE_LIM) begin
            state_d = ST_ALIGN;
          end else if (abs_err_q > UNLOCK_LIM) begin
            state_d = ST_FINE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A sample cannot coincide with expiry: any strobe kicks the watchdog first.
    if (!done_q && wd_expired) begin
      state_d = ST_HOLDOVER;
    end

    if (state_d != state_q) begin
      good_d = '0;
      if (state_d == ST_ALIGN) begin
        div_rst_d     = 1'b1;
        integ_clear_d = 1'b1;
      end
      if (state_q == ST_COARSE && state_d == ST_FINE) begin
        integ_clear_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (!CLK_RST) begin
      done_q        <= 1'b0;
      abs_err_q     <= '0;
      state_q       <= ST_IDLE;
      good_q        <= '0;
      div_rst_q     <= 1'b0;
      integ_clear_q <= 1'b0;
    end else begin
      done_q        <= done_d;
      abs_err_q     <= abs_err_d;
      state_q       <= state_d;
      good_q        <= good_d;
      div_rst_q     <= div_rst_d;
      integ_clear_q <= integ_clear_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_FINE:   bus.Loop_Gain_Sel = GAIN_FINE;
      ST_LOCKED: bus.Loop_Gain_Sel = GAIN_LOCK;
      default:   bus.Loop_Gain_Sel = GAIN_COARSE;
    endcase
  end

  assign bus.State       = state_q;
  assign bus.Loop_En     = (state_q == ST_COARSE) || (state_q == ST_FINE) || (state_q == ST_LOCKED);
  assign bus.Integ_Clear = integ_clear_q;
  assign bus.DIV_RST     = div_rst_q;
  assign bus.Holdover    = (state_q == ST_HOLDOVER);
  assign bus.Led_Lock    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: directed scenarios plus random sample streams
// compared against a rule-level reference model.
module tb_loop_sequencer;

  localparam int NOM = 1_000_000;
  localparam int TO  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  loop_sequencer_if bus();

  loop_sequencer #(
    .PPS_TIMEOUT (TO)
  ) dut (
    .CLK_SYS (clk),
    .CLK_RST (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 align, 2 coarse, 3 fine, 4 locked, 5 holdover.
  int m_state = 0;
  int m_good  = 0;
  bit m_div   = 1'b0;
  bit m_ic    = 1'b0;

  function automatic void model_go(input int s);
    m_state = s;
    m_good  = 0;
    if (s == 1) begin
      m_div = 1'b1;
      m_ic  = 1'b1;
    end
  endfunction

  function automatic void model_sample(input int phase);
    int ad;
    ad = phase - NOM;
    if (ad < 0) ad = -ad;
    m_div = 1'b0;
    m_ic  = 1'b0;
    case (m_state)
      0, 5: model_go(1);
      1:    model_go(2);
      2: begin
        m_good = (ad <= 50) ? ((m_good < 31) ? m_good + 1 : 31) : 0;
        if (m_good == 4) begin
          model_go(3);
          m_ic = 1'b1;
        end
      end
      3: begin
        if (ad > 50) model_go(1);
        else begin
          m_good = (ad <= 4) ? ((m_good < 31) ? m_good + 1 : 31) : 0;
          if (m_good == 16) model_go(4);
        end
      end
      4: begin
        if (ad > 50) model_go(1);
        else if (ad > 20) model_go(3);
      end
      default: model_go(0);
    endcase
  endfunction

  function automatic void model_quiet();
    m_div = 1'b0;
    m_ic  = 1'b0;
  endfunction

  function automatic logic [10:0] exp_vec();
    logic       en;
    logic [1:0] g;
    en = (m_state >= 2) && (m_state <= 4);
    g  = (m_state == 3) ? 2'd1 : ((m_state == 4) ? 2'd2 : 2'd0);
    return {3'(m_state), en, g, m_ic, m_div, (m_state == 5), (m_state == 4)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {bus.State, bus.Loop_En, bus.Loop_Gain_Sel, bus.Integ_Clear,
            bus.DIV_RST, bus.Holdover, bus.Led_Lock};
  endfunction

  function automatic int rand_phase();
    int r;
    int d;
    r = int'($urandom_range(0, 99));
    if (r < 85)      d = int'($urandom_range(0, 4));
    else if (r < 91) d = int'($urandom_range(5, 20));
    else if (r < 96) d = int'($urandom_range(21, 50));
    else             d = int'($urandom_range(51, 900_000));
    return ($urandom_range(0, 1) != 0) ? NOM + d : NOM - d;
  endfunction

  // One strobe; returns at the sampling point after the 2-edge latency.
  task automatic drive_sample(input int phase);
    @(negedge clk);
    bus.Measure_Done  = 1'b1;
    bus.Measure_Phase = 24'(phase);
    @(negedge clk);
    bus.Measure_Done  = 1'b0;
    bus.Measure_Phase = 24'($urandom);
    @(negedge clk);
    model_sample(phase);
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    bus.Measure_Done  = 1'b1;
    bus.Measure_Phase = 24'(NOM);
    repeat (2) @(negedge clk);
    m_state = 0; m_good = 0; model_quiet();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", dut_vec(), exp_vec());
    end
    bus.Measure_Done = 1'b0;
    rst_n            = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle_hold got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_align_coarse();
    drive_sample(NOM);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL align_entry got %h expected %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    model_quiet();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL align_pulse_width got %h expected %h", dut_vec(), exp_vec());
    end
    drive_sample(NOM);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL coarse_entry got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fine_lock();
    for (int i = 0; i < 4; i++) begin
      drive_sample(NOM + 30);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL coarse_to_fine[%0d] got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive_sample((i == 3) ? NOM + 10 : NOM + 3);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fine_to_lock[%0d] got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_unlock();
    drive_sample(NOM + 25);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL locked_to_fine got %h expected %h", dut_vec(), exp_vec());
    end
    drive_sample(999_900);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL fine_to_align got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    drive_sample(NOM);
    for (int i = 0; i < 4; i++) drive_sample(NOM - 40);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_setup got %h expected %h", dut_vec(), exp_vec());
    end
    model_quiet();
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_early got %h expected %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    model_go(5);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_holdover got %h expected %h", dut_vec(), exp_vec());
    end
    repeat (5) @(negedge clk);
    drive_sample(NOM + 500);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL holdover_exit got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_terminal();
    drive_sample(NOM + 7);
    repeat (TO - 2) @(negedge clk);
    drive_sample(NOM + 7);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL terminal_strobe got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    drive_sample(NOM - 10);
    @(negedge clk);
    bus.Measure_Done  = 1'b1;
    bus.Measure_Phase = 24'(NOM + 20);
    @(negedge clk);
    bus.Measure_Phase = 24'(NOM - 30);
    @(negedge clk);
    bus.Measure_Done  = 1'b0;
    @(negedge clk);
    model_sample(NOM + 20);
    model_sample(NOM - 30);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL back_to_back got %h expected %h", dut_vec(), exp_vec());
    end
    @(negedge clk);
    model_quiet();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL b2b_pulse_width got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_pulse();
    drive_sample(999_000);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset_align got %h expected %h", dut_vec(), exp_vec());
    end
    rst_n = 1'b0;
    @(negedge clk);
    m_state = 0; m_good = 0; model_quiet();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_abort got %h expected %h", dut_vec(), exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 300; i++) begin
      p = rand_phase();
      drive_sample(p);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d] phase %0d got %h expected %h", i, p, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.Measure_Done  = 1'b0;
    bus.Measure_Phase = '0;
    test_reset();
    test_align_coarse();
    test_fine_lock();
    test_unlock();
    test_timeout();
    test_terminal();
    test_back_to_back();
    test_reset_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
